// File: rtl/result_display_driver_pkg.sv
// display_pkg: shared converter state type, blank pattern and hex-to-segment encoder
package display_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, UPDATE} conv_state_t;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    // Active-low, bit order g..a
    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        case (h)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction
endpackage

// File: rtl/result_display_driver_if.sv
// result_display_driver_if: value/select inputs and display outputs between calculator and display driver
interface result_display_driver_if #(parameter int WIDTH = 16, parameter int NUM_DIGITS = 8);
    logic [WIDTH-1:0]      DataIn;
    logic [WIDTH-1:0]      DataOut;
    logic                  toDisplaySel;
    logic                  DecMode;
    logic [6:0]            Segments;
    logic [NUM_DIGITS-1:0] Anodes;
    logic                  DP;
    logic                  Valid;
    modport master(output DataIn, DataOut, toDisplaySel, DecMode, input Segments, Anodes, DP, Valid);
    modport slave(input DataIn, DataOut, toDisplaySel, DecMode, output Segments, Anodes, DP, Valid);
endinterface

// File: rtl/result_display_driver_bin_to_bcd.sv
// bin_to_bcd: free-running double-dabble converter; refreshes the digit register every WIDTH+2 cycles
module bin_to_bcd
    import display_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int NUM_DIGITS = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [WIDTH-1:0]        i_value,
    input  logic                    i_dec_mode,
    output logic [4*NUM_DIGITS-1:0] o_digits,
    output logic                    o_valid
);
    localparam int DW = 4 * NUM_DIGITS;
    localparam int SW = WIDTH + DW;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    conv_state_t    r_state;
    logic [SW-1:0]    r_sr;
    logic [WIDTH-1:0] r_hex;
    logic             r_dec;
    logic [CW-1:0]    r_cnt;
    logic [DW-1:0]    r_digits;
    logic             r_valid;
    logic [SW-1:0]    w_adj;
    always_comb begin
        w_adj = r_sr;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (r_sr[WIDTH+4*i +: 4] >= 4'd5) w_adj[WIDTH+4*i +: 4] = r_sr[WIDTH+4*i +: 4] + 4'd3;
    end
    // Hex mode still runs the full shift so the update period never depends on the mode
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_sr     <= '0;
            r_hex    <= '0;
            r_dec    <= 1'b0;
            r_cnt    <= '0;
            r_digits <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_sr    <= SW'(i_value);
                    r_hex   <= i_value;
                    r_dec   <= i_dec_mode;
                    r_cnt   <= '0;
                    r_state <= SHIFT;
                end
                SHIFT: begin
                    r_sr  <= w_adj << 1;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(WIDTH - 1)) r_state <= UPDATE;
                end
                UPDATE: begin
                    r_digits <= r_dec ? r_sr[SW-1 -: DW] : DW'(r_hex);
                    r_valid  <= 1'b1;
                    r_state  <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    assign o_digits = r_digits;
    assign o_valid  = r_valid;
endmodule

// File: rtl/result_display_driver.sv
// result_display_driver: selects the calculator value, converts it and scans it onto a
// multiplexed active-low seven-segment display with leading-zero blanking
module result_display_driver
    import display_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int NUM_DIGITS  = 8,
    parameter int REFRESH_MAX = 50000
) (
    input logic                   clk,
    input logic                   reset,
    result_display_driver_if.slave bus
);
    localparam int RW = $clog2(REFRESH_MAX);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    logic [WIDTH-1:0]        w_value;
    logic [4*NUM_DIGITS-1:0] w_digits;
    logic                    w_valid;
    logic [RW-1:0]           r_refresh;
    logic [IW-1:0]           r_idx;
    logic                    w_wrap;
    logic [IW-1:0]           w_idx_next;
    logic                    w_nonzero;
    logic [NUM_DIGITS-1:0]   w_blank;
    logic [6:0]              r_seg;
    logic [NUM_DIGITS-1:0]   r_an;
    assign w_value = bus.toDisplaySel ? bus.DataIn : bus.DataOut;
    bin_to_bcd #(.WIDTH(WIDTH), .NUM_DIGITS(NUM_DIGITS)) u_conv (
        .clk        (clk),
        .reset      (reset),
        .i_value    (w_value),
        .i_dec_mode (bus.DecMode),
        .o_digits   (w_digits),
        .o_valid    (w_valid)
    );
    always_comb begin
        w_wrap     = r_refresh == RW'(REFRESH_MAX - 1);
        w_idx_next = w_wrap ? ((r_idx == IW'(NUM_DIGITS - 1)) ? '0 : r_idx + 1'b1) : r_idx;
    end
    // A digit is blank when it and every more significant digit are zero
    always_comb begin
        w_nonzero = 1'b0;
        w_blank   = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            w_nonzero  = w_nonzero | (w_digits[4*i +: 4] != 4'd0);
            w_blank[i] = (i != 0) && !w_nonzero;
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_refresh <= '0;
            r_idx     <= '0;
            r_seg     <= SEG_BLANK;
            r_an      <= '1;
        end else begin
            r_refresh <= w_wrap ? '0 : r_refresh + 1'b1;
            r_idx     <= w_idx_next;
            r_seg     <= w_blank[w_idx_next] ? SEG_BLANK : hex_to_seg(w_digits[{w_idx_next, 2'b00} +: 4]);
            r_an      <= ~(NUM_DIGITS'(1) << w_idx_next);
        end
    end
    assign bus.Segments = r_seg;
    assign bus.Anodes   = r_an;
    assign bus.DP       = 1'b1;
    assign bus.Valid    = w_valid;
endmodule

// File: tb/tb_result_display_driver.sv
// tb_result_display_driver: randomized and directed checks of the display driver against an arithmetic digit model
module tb_result_display_driver;
    localparam int W = 16;
    localparam int N = 8;
    localparam int R = 4;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;
    result_display_driver_if #(.WIDTH(W), .NUM_DIGITS(N)) bus ();
    result_display_driver #(.WIDTH(W), .NUM_DIGITS(N), .REFRESH_MAX(R)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );
    int errors = 0;
    int checks = 0;
    logic [6:0] seg_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    typedef struct {
        bit          sel;
        logic [15:0] din;
        logic [15:0] dout;
        bit          dec;
    } vec_t;
    logic [6:0] sc_seg [N];
    bit         sc_seen [N];
    int         sc_incons;
    int         sc_nonhot;
    function automatic logic [6:0] model_seg(input int unsigned v, input bit dec, input int i);
        longint unsigned base = dec ? 10 : 16;
        longint unsigned p = 1;
        for (int k = 0; k < i; k++) p = p * base;
        if (i > 0 && (v / p) == 0) return 7'h7F;
        return seg_tab[int'((v / p) % base)];
    endfunction
    task automatic wait_valid(input int bound, output int cyc);
        cyc = -1;
        for (int c = 1; c <= bound; c++) begin
            @(negedge clk);
            if (bus.Valid) begin
                cyc = c;
                return;
            end
        end
    endtask
    task automatic scan(input int cycles);
        sc_incons = 0;
        sc_nonhot = 0;
        for (int i = 0; i < N; i++) sc_seen[i] = 1'b0;
        repeat (cycles) begin
            int idx, nlow;
            @(negedge clk);
            idx = -1;
            nlow = 0;
            for (int i = 0; i < N; i++) if (!bus.Anodes[i]) begin nlow++; idx = i; end
            if (nlow != 1) sc_nonhot++;
            else if (sc_seen[idx] && sc_seg[idx] !== bus.Segments) sc_incons++;
            else begin sc_seen[idx] = 1'b1; sc_seg[idx] = bus.Segments; end
        end
    endtask
    task automatic load(input vec_t v, output bit ok);
        int c1, c2;
        bus.toDisplaySel = v.sel;
        bus.DataIn = v.din;
        bus.DataOut = v.dout;
        bus.DecMode = v.dec;
        wait_valid(40, c1);
        wait_valid(40, c2);
        ok = (c1 > 0) && (c2 > 0);
        scan(36);
    endtask
    task automatic test_reset();
        int cyc;
        bus.DataIn = 16'h0;
        bus.DataOut = 16'h0;
        bus.toDisplaySel = 1'b0;
        bus.DecMode = 1'b0;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.Anodes !== 8'hFF) begin errors++; $display("FAIL reset_anodes: got %b expected %b", bus.Anodes, 8'hFF); end
        checks++; if (bus.Segments !== 7'h7F) begin errors++; $display("FAIL reset_segments: got %b expected %b", bus.Segments, 7'h7F); end
        checks++; if (bus.DP !== 1'b1) begin errors++; $display("FAIL reset_dp: got %b expected 1", bus.DP); end
        checks++; if (bus.Valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.Valid); end
        reset = 1'b1;
        @(negedge clk);
        checks++; if (bus.Anodes !== 8'hFE) begin errors++; $display("FAIL first_anodes: got %b expected %b", bus.Anodes, 8'hFE); end
        checks++; if (bus.Segments !== 7'b1000000) begin errors++; $display("FAIL first_segments: got %b expected %b", bus.Segments, 7'b1000000); end
        wait_valid(40, cyc);
        checks++; if (cyc + 1 !== 18) begin errors++; $display("FAIL first_valid_cycle: got %0d expected 18", cyc + 1); end
        wait_valid(40, cyc);
        checks++; if (cyc !== 18) begin errors++; $display("FAIL valid_period: got %0d expected 18", cyc); end
        scan(36);
        checks++; if (sc_nonhot !== 0 || sc_incons !== 0) begin errors++; $display("FAIL reset_scan_stability: got nonhot=%0d incons=%0d expected 0/0", sc_nonhot, sc_incons); end
        for (int i = 0; i < N; i++) begin
            logic [6:0] exp;
            exp = (i == 0) ? 7'b1000000 : 7'h7F;
            checks++; if (!sc_seen[i] || sc_seg[i] !== exp) begin errors++; $display("FAIL reset_digit%0d: got %b (seen=%0d) expected %b", i, sc_seg[i], sc_seen[i], exp); end
        end
    endtask
    task automatic test_directed();
        vec_t vecs [5] = '{
            '{1'b0, 16'h1234, 16'h00A5, 1'b0},
            '{1'b0, 16'h1234, 16'h00A5, 1'b1},
            '{1'b0, 16'h0000, 16'hFFFF, 1'b1},
            '{1'b0, 16'h0000, 16'hFFFF, 1'b0},
            '{1'b1, 16'h0B07, 16'h4321, 1'b0}};
        foreach (vecs[t]) begin
            bit ok;
            int unsigned v;
            load(vecs[t], ok);
            v = vecs[t].sel ? vecs[t].din : vecs[t].dout;
            checks++; if (!ok) begin errors++; $display("FAIL directed%0d_valid: no Valid within bound, expected pulses", t); end
            checks++; if (sc_nonhot !== 0 || sc_incons !== 0) begin errors++; $display("FAIL directed%0d_scan: got nonhot=%0d incons=%0d expected 0/0", t, sc_nonhot, sc_incons); end
            for (int i = 0; i < N; i++) begin
                checks++; if (!sc_seen[i] || sc_seg[i] !== model_seg(v, vecs[t].dec, i)) begin
                    errors++; $display("FAIL directed%0d_digit%0d: got %b (seen=%0d) expected %b", t, i, sc_seg[i], sc_seen[i], model_seg(v, vecs[t].dec, i));
                end
            end
        end
    endtask
    task automatic test_random();
        for (int t = 0; t < 8; t++) begin
            vec_t vr;
            bit ok;
            int unsigned v;
            vr.sel = 1'($urandom_range(0, 1));
            vr.dec = 1'($urandom_range(0, 1));
            vr.din = 16'($urandom_range(0, 65535) >> $urandom_range(0, 15));
            vr.dout = 16'($urandom_range(0, 65535) >> $urandom_range(0, 15));
            load(vr, ok);
            v = vr.sel ? vr.din : vr.dout;
            checks++; if (!ok) begin errors++; $display("FAIL random%0d_valid: no Valid within bound, expected pulses", t); end
            for (int i = 0; i < N; i++) begin
                checks++; if (!sc_seen[i] || sc_seg[i] !== model_seg(v, vr.dec, i)) begin
                    errors++; $display("FAIL random%0d_digit%0d v=%0h dec=%0d: got %b expected %b", t, i, v, vr.dec, sc_seg[i], model_seg(v, vr.dec, i));
                end
            end
        end
    endtask
    task automatic test_scan();
        int prev = -1, run = 0, wraps = 0;
        bit started = 1'b0;
        repeat (80) begin
            int idx, nlow;
            @(negedge clk);
            idx = -1;
            nlow = 0;
            for (int i = 0; i < N; i++) if (!bus.Anodes[i]) begin nlow++; idx = i; end
            checks++; if (nlow !== 1) begin errors++; $display("FAIL scan_onehot: got %b expected exactly one low bit", bus.Anodes); end
            if (idx == prev) run++;
            else begin
                if (prev >= 0) begin
                    if (started) begin
                        checks++; if (run !== R) begin errors++; $display("FAIL scan_hold: got %0d cycles expected %0d", run, R); end
                    end
                    checks++; if (idx !== (prev + 1) % N) begin errors++; $display("FAIL scan_order: got digit %0d expected %0d", idx, (prev + 1) % N); end
                    if (prev == N - 1 && idx == 0) wraps++;
                    started = 1'b1;
                end
                prev = idx;
                run = 1;
            end
        end
        checks++; if (wraps < 1) begin errors++; $display("FAIL scan_wrap: got %0d wraps expected at least 1", wraps); end
    endtask
    task automatic test_mid_toggle();
        logic [6:0] d0 [10];
        bit d0_seen [10];
        bit d0_bad [10];
        int nv = 0, since = 0;
        for (int i = 0; i < 10; i++) begin d0_seen[i] = 1'b0; d0_bad[i] = 1'b0; d0[i] = '0; end
        bus.DataIn = 16'd7;
        bus.DataOut = 16'd9;
        bus.toDisplaySel = 1'b1;
        bus.DecMode = 1'b0;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int c = 1; c <= 220 && nv < 9; c++) begin
            @(negedge clk);
            since++;
            if (!bus.Anodes[0]) begin
                if (d0_seen[nv] && d0[nv] !== bus.Segments) d0_bad[nv] = 1'b1;
                d0_seen[nv] = 1'b1;
                d0[nv] = bus.Segments;
            end
            if (bus.Valid) begin nv++; since = 0; end
            if (nv == 6 && since == 3) bus.toDisplaySel = 1'b0;
        end
        checks++; if (nv !== 9) begin errors++; $display("FAIL toggle_valid_count: got %0d expected 9", nv); end
        checks++; if (!d0_seen[7] || d0_bad[7] || d0[7] !== seg_tab[7]) begin errors++; $display("FAIL toggle_first: got %b (seen=%0d) expected %b", d0[7], d0_seen[7], seg_tab[7]); end
        checks++; if (!d0_seen[8] || d0_bad[8] || d0[8] !== seg_tab[9]) begin errors++; $display("FAIL toggle_second: got %b (seen=%0d) expected %b", d0[8], d0_seen[8], seg_tab[9]); end
    endtask
    task automatic test_reset_abort();
        vec_t v = '{1'b0, 16'h0000, 16'h1234, 1'b0};
        bit ok;
        int cyc;
        load(v, ok);
        checks++; if (!ok || sc_seg[0] !== seg_tab[4]) begin errors++; $display("FAIL abort_pre: got %b expected %b", sc_seg[0], seg_tab[4]); end
        wait_valid(40, cyc);
        repeat (5) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checks++; if (bus.Anodes !== 8'hFF || bus.Segments !== 7'h7F || bus.Valid !== 1'b0) begin
            errors++; $display("FAIL abort_async: got an=%b seg=%b valid=%b expected 11111111/1111111/0", bus.Anodes, bus.Segments, bus.Valid);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++; if (bus.Anodes !== 8'hFE || bus.Segments !== 7'b1000000) begin
            errors++; $display("FAIL abort_cleared: got an=%b seg=%b expected 11111110/1000000", bus.Anodes, bus.Segments);
        end
        wait_valid(40, cyc);
        checks++; if (cyc + 1 !== 18) begin errors++; $display("FAIL abort_restart: got %0d expected 18", cyc + 1); end
    endtask
    initial begin
        test_reset();
        test_directed();
        test_random();
        test_scan();
        test_mid_toggle();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
